// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester-side controller.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // Number of bits needed to count 0..value-1 (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after the pointer, wrapping.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]        o_grant
);

  localparam int unsigned PTR_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_at_or_after;
  logic [NUM_REQ-1:0] w_hi_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_at_or_after[gi] = (PTR_W'(gi) >= i_ptr);
    end
  endgenerate

  // Lowest set bit among requests at/after the pointer, else lowest overall (wrap).
  always_comb begin
    w_hi_req = i_req & w_at_or_after;
    if (|w_hi_req) o_grant = w_hi_req & (~w_hi_req + NUM_REQ'(1));
    else           o_grant = i_req & (~i_req + NUM_REQ'(1));
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB requester-side controller: round-robin arbitration, APB phase sequencing,
// response return and a timeout guard against a non-responding slave.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      P_clk,
  input  logic                      P_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      P_sel,
  output logic                      P_enable,
  output logic                      P_write,
  output logic [ADDR_W-1:0]         P_addr,
  output logic [DATA_W-1:0]         P_wdata,
  input  logic [DATA_W-1:0]         P_rdata,
  input  logic                      P_ready,
  input  logic                      P_slverr
);

  localparam int unsigned PTR_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(TIMEOUT);

  apb_state_t          r_state, w_state_next;
  logic [PTR_W-1:0]    r_ptr, w_gidx, w_ptr_next;
  logic [NUM_REQ-1:0]  r_gnt, w_grant;
  logic                r_write, w_sel_write;
  logic [ADDR_W-1:0]   r_addr, w_sel_addr;
  logic [DATA_W-1:0]   r_wdata, w_sel_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_timeout, w_done;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Pick the winner's request fields and the pointer value that follows it.
  always_comb begin
    w_gidx      = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx      = PTR_W'(i);
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
    w_ptr_next = (w_gidx == PTR_W'(NUM_REQ-1)) ? '0 : w_gidx + PTR_W'(1);
  end

  // Next-state decode and APB/grant outputs; address/data are masked to 0 in IDLE.
  always_comb begin
    w_timeout    = (r_cnt == CNT_W'(TIMEOUT-1));
    w_done       = (r_state == APB_ACCESS) && (P_ready || w_timeout);
    w_state_next = r_state;
    req_ready    = '0;
    P_sel        = 1'b0;
    P_enable     = 1'b0;
    P_write      = 1'b0;
    P_addr       = '0;
    P_wdata      = '0;
    unique case (r_state)
      APB_IDLE: begin
        req_ready = w_grant;
        if (|w_grant) w_state_next = APB_SETUP;
      end
      APB_SETUP: begin
        P_sel        = 1'b1;
        P_write      = r_write;
        P_addr       = r_addr;
        P_wdata      = r_wdata;
        w_state_next = APB_ACCESS;
      end
      APB_ACCESS: begin
        P_sel    = 1'b1;
        P_enable = 1'b1;
        P_write  = r_write;
        P_addr   = r_addr;
        P_wdata  = r_wdata;
        if (w_done) w_state_next = APB_IDLE;
      end
      default: w_state_next = APB_IDLE;
    endcase
  end

  // State register, request capture, timeout counter and registered response.
  always_ff @(posedge P_clk) begin
    if (P_reset) begin
      r_state     <= APB_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      unique case (r_state)
        APB_IDLE: begin
          if (|w_grant) begin
            r_gnt   <= w_grant;
            r_write <= w_sel_write;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_ptr   <= w_ptr_next;
          end
        end
        APB_SETUP: r_cnt <= '0;
        APB_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            // A real P_ready wins over a coincident timeout.
            r_rsp_valid <= r_gnt;
            r_rsp_err   <= P_ready ? P_slverr : 1'b1;
            r_rsp_rdata <= (P_ready && !P_slverr && !r_write) ? P_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a registered-ready APB slave model.
module tb_apb_master_arbiter;

  logic        P_clk = 1'b0;
  logic        P_reset;
  logic [1:0]  req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        P_sel, P_enable, P_write;
  logic [7:0]  P_addr, P_wdata, P_rdata;
  logic        P_ready, P_slverr;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model controls
  int unsigned sl_wait   = 1;     // low ACCESS cycles before ready; 0 = never ready
  logic        sl_err    = 1'b0;
  logic        sl_manual = 1'b0;  // drive P_ready directly from man_ready
  logic        man_ready = 1'b0;
  logic        sl_ready_q;
  int unsigned sl_cnt;
  logic [7:0]  mem [256];

  apb_master_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .P_clk(P_clk), .P_reset(P_reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata),
    .P_rdata(P_rdata), .P_ready(P_ready), .P_slverr(P_slverr)
  );

  always #5 P_clk = ~P_clk;

  assign P_ready  = sl_manual ? man_ready : sl_ready_q;
  assign P_rdata  = mem[P_addr];
  assign P_slverr = sl_err;

  // Slave: registers P_ready, so the earliest completion is the 2nd ACCESS cycle.
  always @(posedge P_clk) begin
    if (P_reset) begin
      sl_ready_q <= 1'b0;
      sl_cnt     <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hFF;
    end else begin
      if (P_sel && P_enable && P_ready && P_write && !P_slverr) mem[P_addr] <= P_wdata;
      if (sl_ready_q) begin
        sl_ready_q <= 1'b0;
        sl_cnt     <= 0;
      end else if (P_sel && P_enable) begin
        if (sl_wait != 0 && sl_cnt + 1 == sl_wait) sl_ready_q <= 1'b1;
        sl_cnt <= sl_cnt + 1;
      end else begin
        sl_cnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Follow one transfer from grant to the response cycle; returns at negedge+1 of that cycle.
  task automatic observe(input bit drop, output int gnt, output int acc,
                         output logic [7:0] paddr, output logic pwrite, output logic stable,
                         output logic [1:0] rspv, output logic [7:0] rdata, output logic err,
                         output bit ok);
    logic [1:0] g;
    logic [7:0] pwdata;
    ok = 1; stable = 1; acc = 0; gnt = -1; g = '0;
    paddr = '0; pwrite = 1'b0; pwdata = '0; rspv = '0; rdata = '0; err = 1'b0;
    #1;
    for (int i = 0; i < 50 && g == 2'b00; i++) begin
      if (|req_ready) g = req_ready;
      else begin @(negedge P_clk); #1; end
    end
    if (g == 2'b00) begin ok = 0; return; end
    gnt = g[1] ? 1 : 0;
    @(negedge P_clk); #1;
    if (!(P_sel && !P_enable)) ok = 0;
    paddr = P_addr; pwdata = P_wdata; pwrite = P_write;
    if (drop) req_valid[gnt] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge P_clk); #1;
      if (P_sel && P_enable) begin
        acc++;
        if (P_addr !== paddr || P_wdata !== pwdata || P_write !== pwrite || |rsp_valid) stable = 0;
      end else break;
    end
    if (P_sel) ok = 0;
    rspv = rsp_valid; rdata = rsp_rdata; err = rsp_err;
  endtask

  typedef struct {
    int unsigned rq;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int unsigned wt;
    logic        serr;
    int unsigned exp_acc;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int gnt, acc;
    logic [7:0] paddr, rdata;
    logic pwrite, stable, err;
    logic [1:0] rspv;
    bit ok;
    logic saw_rsp;

    //          rq wr    addr   wdata  wt serr   acc rdata  err
    vecs[0] = '{0, 1'b1, 8'h12, 8'hA5, 1, 1'b0,  2, 8'h00, 1'b0};  // write
    vecs[1] = '{0, 1'b0, 8'h12, 8'h00, 1, 1'b0,  2, 8'hA5, 1'b0};  // read back
    vecs[2] = '{1, 1'b1, 8'h34, 8'h5C, 5, 1'b0,  6, 8'h00, 1'b0};  // 5 wait states
    vecs[3] = '{1, 1'b0, 8'h34, 8'h00, 1, 1'b0,  2, 8'h5C, 1'b0};
    vecs[4] = '{0, 1'b0, 8'h12, 8'h00, 1, 1'b1,  2, 8'h00, 1'b1};  // slave error
    vecs[5] = '{1, 1'b1, 8'h56, 8'h77, 0, 1'b0, 16, 8'h00, 1'b1};  // timeout
    vecs[6] = '{0, 1'b0, 8'h56, 8'h00, 1, 1'b0,  2, 8'hA9, 1'b0};  // timed-out write not applied
    vecs[7] = '{1, 1'b0, 8'h12, 8'h00, 3, 1'b0,  4, 8'hA5, 1'b0};

    P_reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge P_clk);
    #1;
    chk("reset_outs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, P_sel, P_enable, P_write}), 32'd0);
    chk("reset_addr_data", 32'({P_addr, P_wdata}), 32'd0);
    @(negedge P_clk);
    P_reset = 1'b0;
    @(negedge P_clk); #1;
    chk("idle_no_req", 32'({req_ready, rsp_valid, P_sel, P_enable}), 32'd0);

    for (int v = 0; v < 8; v++) begin
      sl_wait = vecs[v].wt;
      sl_err  = vecs[v].serr;
      req_write[vecs[v].rq]           = vecs[v].wr;
      req_addr[vecs[v].rq*8 +: 8]     = vecs[v].addr;
      req_wdata[vecs[v].rq*8 +: 8]    = vecs[v].wdata;
      req_valid[vecs[v].rq]           = 1'b1;
      observe(1'b1, gnt, acc, paddr, pwrite, stable, rspv, rdata, err, ok);
      chk($sformatf("v%0d_ok", v), 32'(ok), 32'd1);
      chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(vecs[v].rq));
      chk($sformatf("v%0d_paddr", v), 32'(paddr), 32'(vecs[v].addr));
      chk($sformatf("v%0d_pwrite", v), 32'(pwrite), 32'(vecs[v].wr));
      chk($sformatf("v%0d_stable", v), 32'(stable), 32'd1);
      chk($sformatf("v%0d_access_cycles", v), 32'(acc), 32'(vecs[v].exp_acc));
      chk($sformatf("v%0d_rsp_valid", v), 32'(rspv), 32'd1 << vecs[v].rq);
      chk($sformatf("v%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_rdata));
      chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      @(negedge P_clk); #1;
      chk($sformatf("v%0d_rsp_pulse", v), 32'(rsp_valid), 32'd0);
    end
    sl_err = 1'b0;

    // Stale P_ready=1 through IDLE/SETUP must not end the transfer before ACCESS.
    sl_manual = 1'b1; man_ready = 1'b1;
    req_write[1] = 1'b0; req_addr[15:8] = 8'h34; req_valid[1] = 1'b1;
    observe(1'b1, gnt, acc, paddr, pwrite, stable, rspv, rdata, err, ok);
    chk("stale_ok", 32'(ok), 32'd1);
    chk("stale_access_cycles", 32'(acc), 32'd1);
    chk("stale_rdata", 32'(rdata), 32'h5C);
    chk("stale_rsp_valid", 32'(rspv), 32'd2);
    sl_manual = 1'b0; man_ready = 1'b0;
    repeat (2) @(negedge P_clk);

    // Reset in the middle of ACCESS abandons the transfer silently.
    sl_wait = 0;
    req_write[0] = 1'b0; req_addr[7:0] = 8'h12; req_valid[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge P_clk); #1;
      if (P_sel) req_valid[0] = 1'b0;
      if (P_enable) begin ok = 1; break; end
    end
    chk("midrst_reached_access", 32'(ok), 32'd1);
    repeat (2) @(negedge P_clk);
    P_reset = 1'b1;
    @(negedge P_clk); #1;
    chk("midrst_outs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, P_sel, P_enable, P_write}), 32'd0);
    chk("midrst_addr_data", 32'({P_addr, P_wdata}), 32'd0);
    P_reset = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge P_clk); #1;
      if (|rsp_valid || P_sel) saw_rsp = 1'b1;
    end
    chk("midrst_no_rsp", 32'(saw_rsp), 32'd0);

    // Contention after reset: pointer is 0, so grants go 0,1,0,1 at full rate.
    sl_wait = 1;
    req_write = 2'b11;
    req_addr  = {8'h41, 8'h40};
    req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      observe(1'b0, gnt, acc, paddr, pwrite, stable, rspv, rdata, err, ok);
      chk($sformatf("cont%0d_gnt", k), 32'(gnt), 32'(k % 2));
      chk($sformatf("cont%0d_paddr", k), 32'(paddr), 32'h40 + 32'(k % 2));
      chk($sformatf("cont%0d_access_cycles", k), 32'(acc), 32'd2);
      chk($sformatf("cont%0d_rsp_valid", k), 32'(rspv), 32'd1 << (k % 2));
    end
    req_valid = 2'b00;
    @(negedge P_clk);

    req_write[0] = 1'b0; req_addr[7:0] = 8'h41; req_valid[0] = 1'b1;
    observe(1'b1, gnt, acc, paddr, pwrite, stable, rspv, rdata, err, ok);
    chk("cont_readback_rdata", 32'(rdata), 32'h22);
    chk("cont_readback_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
